// File: rtl/fir_delay_ram_if.sv
// Request/response bundle for the multi-channel FIR delay line.
interface fir_delay_ram_if #(
   parameter int WIDTH    = 36,
   parameter int DEPTH    = 256,
   parameter int CHANNELS = 2
) ();
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                flush;
   logic                wr_en;
   logic [CW-1:0]       wr_chan;
   logic [WIDTH-1:0]    wr_data;
   logic                rd_en;
   logic [CW-1:0]       rd_chan;
   logic [AW-1:0]       rd_tap;
   logic [WIDTH-1:0]    rd_data;
   logic                rd_valid;
   logic [CHANNELS-1:0] fill_full;

   // Filter control side: issues writes, reads and flushes.
   modport master (
      output flush, wr_en, wr_chan, wr_data, rd_en, rd_chan, rd_tap,
      input  rd_data, rd_valid, fill_full
   );

   // Delay line side.
   modport slave (
      input  flush, wr_en, wr_chan, wr_data, rd_en, rd_chan, rd_tap,
      output rd_data, rd_valid, fill_full
   );
endinterface

// File: rtl/fir_delay_ram.sv
// Multi-channel circular sample delay line. Each channel owns a DEPTH-entry
// ring in one shared memory; taps are addressed by age (0 = newest) and
// taps never written since reset/flush read back as zero.
module fir_delay_ram #(
   parameter int WIDTH    = 36,
   parameter int DEPTH    = 256,
   parameter int CHANNELS = 2
) (
   input logic            clock,
   input logic            reset,
   fir_delay_ram_if.slave bus_if
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [WIDTH-1:0]    mem [CHANNELS*DEPTH];

   logic [AW-1:0]       wr_ptr_q [CHANNELS];
   logic [AW-1:0]       wr_ptr_d [CHANNELS];
   logic [AW:0]         fill_q   [CHANNELS];
   logic [AW:0]         fill_d   [CHANNELS];
   logic [CHANNELS-1:0] full_q;

   logic [WIDTH-1:0]    mem_q;
   logic                gate_q;
   logic [1:0]          vld_q;
   logic [WIDTH-1:0]    rd_data_q;

   // Out-of-range channels are steered to channel 0 for indexing only;
   // the ok flags keep them from having any effect.
   logic                wr_ok, rd_ok, mem_we, rd_gate;
   logic [CW-1:0]       wr_idx, rd_idx;
   logic [AW-1:0]       rd_off;
   logic [CW+AW-1:0]    wr_addr, rd_addr;

   assign wr_ok   = int'(bus_if.wr_chan) < CHANNELS;
   assign rd_ok   = int'(bus_if.rd_chan) < CHANNELS;
   assign wr_idx  = wr_ok ? bus_if.wr_chan : '0;
   assign rd_idx  = rd_ok ? bus_if.rd_chan : '0;
   assign mem_we  = bus_if.wr_en && wr_ok && !bus_if.flush;
   assign wr_addr = {wr_idx, wr_ptr_q[wr_idx]};
   // Age -> offset using the pre-write pointer; wraps naturally in AW bits.
   assign rd_off  = wr_ptr_q[rd_idx] - AW'(1) - bus_if.rd_tap;
   assign rd_addr = {rd_idx, rd_off};
   assign rd_gate = !rd_ok || ({1'b0, bus_if.rd_tap} >= fill_q[rd_idx]);

   // Next pointer/fill: flush wins over (and drops) a same-cycle write.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         wr_ptr_d[c] = wr_ptr_q[c];
         fill_d[c]   = fill_q[c];
         if (bus_if.flush) begin
            wr_ptr_d[c] = '0;
            fill_d[c]   = '0;
         end else if (mem_we && (CW'(c) == wr_idx)) begin
            wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
            if (fill_q[c] != FULL)
               fill_d[c] = fill_q[c] + (AW+1)'(1);
         end
      end
   end

   // Per-channel pointer, fill count and registered full flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_q[c] <= '0;
            fill_q[c]   <= '0;
         end
         full_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_q[c] <= wr_ptr_d[c];
            fill_q[c]   <= fill_d[c];
            full_q[c]   <= (fill_d[c] == FULL);
         end
      end
   end

   // Shared RAM, read-first: a read of the slot being written returns the
   // old (oldest) sample, which is the correct age for tap DEPTH-1.
   always_ff @(posedge clock) begin
      if (mem_we)
         mem[wr_addr] <= bus_if.wr_data;
      if (bus_if.rd_en)
         mem_q <= mem[rd_addr];
   end

   // Two-stage read pipeline: RAM word + gate, then gated output register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q     <= '0;
         gate_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         vld_q <= {vld_q[0], bus_if.rd_en};
         if (bus_if.rd_en)
            gate_q <= rd_gate;
         if (vld_q[0])
            rd_data_q <= gate_q ? '0 : mem_q;
      end
   end

   assign bus_if.rd_data   = rd_data_q;
   assign bus_if.rd_valid  = vld_q[1];
   assign bus_if.fill_full = full_q;
endmodule

// File: doc/fir_delay_ram.md
Name: fir_delay_ram

Overview:
- Parametrised, multi-channel circular sample delay line for the polyphase FIR datapath.
- Each channel owns a DEPTH-entry ring in one shared simple-dual-port memory. Writes append the newest sample; reads fetch a tap by age (0 = newest) with fixed latency and a valid strobe.
- Adds per-channel write pointers, fill tracking with zero-gating of unwritten taps, and a flush. This lets filter control logic address taps by age rather than by raw RAM address.

Parameters:
- WIDTH, 36, sample/coefficient word width in bits
- DEPTH, 256, entries per channel; must be a power of 2, at least 2
- CHANNELS, 2, number of independent delay lines; at least 1
- AW, log2(DEPTH), tap/pointer width (derived; not overridden)
- CW, max(1,log2(CHANNELS)), channel index width (derived)

Ports:
- clock  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; clears all pointers and fill counts
- wr_en  in  1  write strobe
- wr_chan  in  CW  channel to write
- wr_data  in  WIDTH  sample to append
- rd_en  in  1  read request
- rd_chan  in  CW  channel to read
- rd_tap  in  AW  sample age; 0 = most recent write
- rd_data  out  WIDTH  tap value, registered
- rd_valid  out  1  one-cycle pulse when rd_data holds a result
- fill_full  out  CHANNELS  bit c is high when channel c holds DEPTH samples

Behaviour:
- Memory organisation:
  - CHANNELS*DEPTH words.
  - Physical address = {chan, offset}.
  - Contents are not reset.
- Per-channel state:
  - wr_ptr[c] (AW bits).
  - fill[c], saturating at DEPTH, AW+1 bits.
- Write (wr_en=1, wr_chan<CHANNELS):
  - mem[{c, wr_ptr[c]}] <= wr_data.
  - wr_ptr[c] <= wr_ptr[c]+1, modulo DEPTH with natural wrap.
  - fill[c] <= min(fill[c]+1, DEPTH).
  - A write with wr_chan >= CHANNELS is ignored.
- Read (rd_en=1):
  - Issue cycle T: offset = wr_ptr[rd_chan]-1-rd_tap, modulo DEPTH, using the pointer value before any same-cycle write.
  - gate = (rd_chan >= CHANNELS) or (rd_tap >= fill[rd_chan]), evaluated at T.
  - Latency is fixed at 2 cycles: the address/gate register is at T+1, and rd_data and rd_valid are valid at T+2.
  - When gate=1, rd_data is 0.
  - A read can be issued every cycle (fully pipelined); back-to-back results appear on consecutive cycles.
  - rd_data holds its last value when rd_valid=0.
- Simultaneous write and read:
  - Reads see pre-write state.
  - Same channel with rd_tap = DEPTH-1 hits the address being written. The memory is read-first, so the returned value is the old (oldest) sample. This is correct age semantics.
  - A write to a different channel has no interaction with the read.
- flush:
  - At the next edge, wr_ptr and fill of every channel go to 0 and fill_full goes to 0.
  - A write in the same cycle as flush is dropped.
  - Reads issued at or before the flush cycle complete with gate values computed at issue.
  - Reads issued after flush return 0 until those taps are rewritten.
- Reset (async assert):
  - wr_ptr=0, fill=0, rd_valid=0, rd_data=0, fill_full=0, and the pipeline valid bits are cleared.
  - Reads in flight are discarded; no rd_valid appears after reset.
  - Release is synchronised externally; no requests are accepted while reset is high.
- fill_full[c] is registered and equals (fill[c]==DEPTH).
- Arithmetic:
  - Pointer and tap arithmetic are AW-bit unsigned with wrap.
  - No data arithmetic is performed; WIDTH passes through unchanged.

Test Plan:
- DEPTH=8, CHANNELS=2: write 1..5 to ch0; read taps 0,1,4,5 of ch0 -> 5,4,1,0 (tap 5 is unfilled and gated), each rd_valid exactly 2 cycles after rd_en.
- Write 1..11 to ch0 (wraps) -> fill_full[0]=1; taps 0..7 -> 11..4; ch1 all taps -> 0 and fill_full[1]=0.
- Ch0 full with 11..4: in the same cycle, write 12 and read tap 7 of ch0 -> 4 (read-first, pre-write pointer); next read of tap 0 -> 12.
- Interleave writes ch0=0xA5A5A5A5A, ch1=0x123456789 with reads every cycle alternating channels -> correct per-channel values, no cross-channel corruption, continuous rd_valid.
- Fill ch0, issue read tap 0 and assert flush the next cycle -> the in-flight read returns the pre-flush value; reads after flush -> 0; fill_full=0.
- Assert reset between rd_en and rd_valid -> rd_valid never pulses and rd_data=0; after release, tap 0 -> 0.
